// File: rtl/layer_stream_sequencer.sv
// Layer stream sequencer: captures a full upstream output vector (NN elements of dataWidth bits)
// and replays it one element per cycle on the downstream single-element input.
// A one-deep pending buffer lets back-to-back vectors stream without gaps.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid[NN]      - per-neuron valids; all high = capture, some high = mismatch
//   in_data           - packed vector, element i at [i*dataWidth +: dataWidth]
//   clr_err           - synchronous clear of sticky error flags (a same-cycle set wins)
//   out_valid/out_data/out_last - registered element stream, out_last on index NN-1
//   busy              - sending or holding a pending vector
//   overflow          - sticky, a complete vector was dropped
//   valid_mismatch    - sticky, in_valid was partially asserted
module layer_stream_sequencer #(
  parameter int unsigned NN        = 20,
  parameter int unsigned dataWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             in_valid,
  input  logic [NN*dataWidth-1:0]   in_data,
  input  logic                      clr_err,
  output logic                      out_valid,
  output logic [dataWidth-1:0]      out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overflow,
  output logic                      valid_mismatch
);

  localparam int unsigned CntW = $clog2(NN + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(NN);
  localparam logic [CntW-1:0] CntLast = CntW'(NN - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                    r_state, w_state_nxt;
  logic [CntW-1:0]           r_cnt, w_cnt_nxt;
  logic [NN*dataWidth-1:0]   r_active, w_active_nxt;
  logic [NN*dataWidth-1:0]   r_pending, w_pending_nxt;
  logic                      r_pend_vld, w_pend_vld_nxt;
  logic                      r_out_valid, w_out_valid_nxt;
  logic [dataWidth-1:0]      r_out_data, w_out_data_nxt;
  logic                      r_out_last, w_out_last_nxt;
  logic                      r_overflow, w_overflow_nxt;
  logic                      r_mismatch, w_mismatch_nxt;

  logic                      w_cap;
  logic                      w_part;
  logic [31:0]               w_base;
  logic [dataWidth-1:0]      w_cur_elem;

  assign w_cap      = &in_valid;
  assign w_part     = (|in_valid) && !w_cap;
  // r_cnt indexes the next element to emit; only read while r_cnt < NN.
  assign w_base     = 32'(r_cnt) * dataWidth;
  assign w_cur_elem = r_active[w_base +: dataWidth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_vld  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_overflow  <= w_overflow_nxt;
      r_mismatch  <= w_mismatch_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_active_nxt    = r_active;
    w_pending_nxt   = r_pending;
    w_pend_vld_nxt  = r_pend_vld;
    w_out_valid_nxt = 1'b0;
    w_out_data_nxt  = '0;
    w_out_last_nxt  = 1'b0;
    // Clear first so a set in the same cycle takes priority.
    w_overflow_nxt  = clr_err ? 1'b0 : r_overflow;
    w_mismatch_nxt  = clr_err ? 1'b0 : r_mismatch;
    if (w_part) begin
      w_mismatch_nxt = 1'b1;
    end

    case (r_state)
      StIdle: begin
        if (w_cap) begin
          w_active_nxt    = in_data;
          w_out_data_nxt  = in_data[dataWidth-1:0];
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = CntOne;
          w_state_nxt     = StSend;
        end
      end
      StSend: begin
        if (r_cnt < CntMax) begin
          w_out_data_nxt  = w_cur_elem;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = (r_cnt == CntLast);
          w_cnt_nxt       = r_cnt + CntOne;
          if (w_cap) begin
            if (!r_pend_vld) begin
              w_pending_nxt  = in_data;
              w_pend_vld_nxt = 1'b1;
            end else begin
              w_overflow_nxt = 1'b1;
            end
          end
        end else if (r_pend_vld) begin
          // Last element is on the outputs: chain straight into the pending vector.
          w_active_nxt    = r_pending;
          w_out_data_nxt  = r_pending[dataWidth-1:0];
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = CntOne;
          w_pend_vld_nxt  = 1'b0;
          if (w_cap) begin
            w_pending_nxt  = in_data;
            w_pend_vld_nxt = 1'b1;
          end
        end else if (w_cap) begin
          w_active_nxt    = in_data;
          w_out_data_nxt  = in_data[dataWidth-1:0];
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = CntOne;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;
  assign busy           = (r_state == StSend) || r_pend_vld;
  assign overflow       = r_overflow;
  assign valid_mismatch = r_mismatch;

endmodule

// File: tb/tb_layer_stream_sequencer.sv
module tb_layer_stream_sequencer;
  localparam int unsigned NN = 4;
  localparam int unsigned DW = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NN-1:0]       in_valid;
  logic [NN*DW-1:0]    in_data;
  logic                clr_err;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic                busy;
  logic                overflow;
  logic                valid_mismatch;

  always #5 clk = ~clk;

  layer_stream_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .clr_err        (clr_err),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .overflow       (overflow),
    .valid_mismatch (valid_mismatch)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;

  // Reference model: a FIFO of elements still to appear on the outputs.
  // A full vector is accepted iff at most one vector's worth of elements is still waiting.
  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } elem_t;
  elem_t         mq[$];
  logic          m_ovf = 1'b0;
  logic          m_mm  = 1'b0;
  logic          e_valid = 1'b0;
  logic [DW-1:0] e_data  = '0;
  logic          e_last  = 1'b0;

  typedef struct {
    logic [NN-1:0]    v;
    logic [NN*DW-1:0] d;
    logic             xv;
    logic [DW-1:0]    xd;
    logic             xl;
    logic             xbusy;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c, input logic [DW-1:0] e);
    return {e, c, b, a};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_mm    = 1'b0;
    e_valid = 1'b0;
    e_data  = '0;
    e_last  = 1'b0;
  endtask

  task automatic model_edge(input logic [NN-1:0] v, input logic [NN*DW-1:0] d, input logic clr);
    if (clr) begin
      m_ovf = 1'b0;
      m_mm  = 1'b0;
    end
    if (&v) begin
      if (mq.size() <= NN) begin
        for (int i = 0; i < NN; i++) begin
          elem_t x;
          x.d    = d[i*DW +: DW];
          x.last = (i == NN - 1);
          mq.push_back(x);
        end
      end else begin
        m_ovf = 1'b1;
      end
    end else if (|v) begin
      m_mm = 1'b1;
    end
    if (mq.size() > 0) begin
      elem_t y;
      y       = mq.pop_front();
      e_valid = 1'b1;
      e_data  = y.d;
      e_last  = y.last;
    end else begin
      e_valid = 1'b0;
      e_data  = '0;
      e_last  = 1'b0;
    end
  endtask

  task automatic step(input logic [NN-1:0] v, input logic [NN*DW-1:0] d, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr_err  = clr;
    @(posedge clk);
    model_edge(v, d, clr);
    #1;
    if (out_valid === 1'b1) vcount++;
    chk("out_valid", out_valid, e_valid);
    chk("out_data", out_data, e_data);
    chk("out_last", out_last, e_last);
    chk("busy", busy, e_valid);
    chk("overflow", overflow, m_ovf);
    chk("valid_mismatch", valid_mismatch, m_mm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  logic [NN*DW-1:0] va, vb, vc;

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    clr_err  = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_mismatch", valid_mismatch, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single vector, expected values written out by hand.
    va = pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    tbl[0] = '{v: 4'hF, d: va, xv: 1'b1, xd: 16'h0011, xl: 1'b0, xbusy: 1'b1};
    tbl[1] = '{v: 4'h0, d: '0, xv: 1'b1, xd: 16'h0022, xl: 1'b0, xbusy: 1'b1};
    tbl[2] = '{v: 4'h0, d: '0, xv: 1'b1, xd: 16'h0033, xl: 1'b0, xbusy: 1'b1};
    tbl[3] = '{v: 4'h0, d: '0, xv: 1'b1, xd: 16'h0044, xl: 1'b1, xbusy: 1'b1};
    tbl[4] = '{v: 4'h0, d: '0, xv: 1'b0, xd: 16'h0000, xl: 1'b0, xbusy: 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, tbl[i].d, 1'b0);
      chk("tbl_valid", out_valid, tbl[i].xv);
      chk("tbl_data", out_data, tbl[i].xd);
      chk("tbl_last", out_last, tbl[i].xl);
      chk("tbl_busy", busy, tbl[i].xbusy);
    end

    // Back-to-back: B captured two cycles after A gives 8 contiguous valid cycles.
    va = pack4(16'hA000, 16'hA001, 16'hA002, 16'hA003);
    vb = pack4(16'hB000, 16'hB001, 16'hB002, 16'hB003);
    vcount = 0;
    step(4'hF, va, 1'b0);
    step('0, '0, 1'b0);
    step(4'hF, vb, 1'b0);
    idle(6);
    chk("b2b_valid_cycles", 64'(vcount), 64'd8);
    chk("b2b_overflow", overflow, 1'b0);

    // Capture in the cycle A3 is on the outputs: B0 follows with no gap.
    step(4'hF, va, 1'b0);
    idle(3);
    chk("a3_last", out_last, 1'b1);
    step(4'hF, vb, 1'b0);
    chk("nogap_valid", out_valid, 1'b1);
    chk("nogap_data", out_data, 16'hB000);
    idle(4);

    // Three consecutive captures: C dropped, overflow sticky until cleared.
    vc = pack4(16'hC000, 16'hC001, 16'hC002, 16'hC003);
    step(4'hF, va, 1'b0);
    step(4'hF, vb, 1'b0);
    step(4'hF, vc, 1'b0);
    idle(8);
    chk("ovf_sticky", overflow, 1'b1);
    step('0, '0, 1'b1);
    chk("ovf_cleared", overflow, 1'b0);

    // Partial valid: no output, mismatch set; set beats a simultaneous clear.
    step(4'b0101, va, 1'b0);
    chk("part_no_valid", out_valid, 1'b0);
    chk("part_mismatch", valid_mismatch, 1'b1);
    step(4'b0011, va, 1'b1);
    chk("part_set_wins", valid_mismatch, 1'b1);
    step('0, '0, 1'b1);
    chk("part_cleared", valid_mismatch, 1'b0);

    // Reset during element 2 with a vector pending.
    step(4'hF, va, 1'b0);
    step(4'hF, vb, 1'b0);
    step('0, '0, 1'b0);
    chk("pre_rst_data", out_data, 16'hA002);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    idle(6);
    chk("post_rst_no_valid", 64'(vcount), 64'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [NN-1:0]    v;
      logic [NN*DW-1:0] d;
      r = $urandom_range(0, 9);
      if (r <= 2)      v = 4'hF;
      else if (r == 3) v = 4'($urandom_range(1, 14));
      else             v = '0;
      d = {$urandom, $urandom};
      step(v, d, ($urandom_range(0, 15) == 0));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_stream_sequencer.md
Name: layer_stream_sequencer

Overview:
- Sits between two fully-connected layers of the NN accelerator.
- Captures the parallel output vector of an upstream layer (NN neurons, dataWidth each, one valid bit per neuron) and replays it one element per cycle on the downstream layer's single shared x_in/x_valid input.
- Provides a one-deep pending buffer so back-to-back vectors stream with no gap, plus sticky error flags for overflow and inconsistent neuron valids.

Parameters:
- NN, 20, number of neurons in the upstream layer (elements per vector); must be >= 2.
- dataWidth, 16, width of each element in bits.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NN  upstream per-neuron o_valid.
- in_data  input  NN*dataWidth  upstream x_out; element i at [i*dataWidth +: dataWidth].
- clr_err  input  1  synchronous clear of the sticky error flags.
- out_valid  output  1  downstream x_valid, registered.
- out_data  output  dataWidth  downstream x_in, registered.
- out_last  output  1  high with the final element (index NN-1) of each vector.
- busy  output  1  high while a vector is being sent or one is pending.
- overflow  output  1  sticky; a complete vector was dropped.
- valid_mismatch  output  1  sticky; in_valid was partially asserted.

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - state=IDLE, cnt=0, pending_valid=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, overflow=0, valid_mismatch=0.
  - Reset mid-vector aborts the transfer and discards the pending vector.
- Capture event cap = &in_valid, sampled at a rising edge. Partial event part = |in_valid && !cap.
- part: no capture; valid_mismatch<=1.
- FSM states:
  - IDLE: on cap, load active buffer from in_data; out_data<=element 0, out_valid<=1, out_last<=0, cnt<=1; go to SEND. Latency from in_valid sampled high to out_valid high is 1 cycle.
  - SEND, cnt<NN: out_data<=active[cnt], out_valid<=1, out_last<=(cnt==NN-1), cnt<=cnt+1.
  - SEND, cnt==NN (last element is on the outputs this cycle), next element comes from:
    - pending_valid=1: move pending to active, emit its element 0, cnt<=1, pending_valid<=0, stay in SEND. A cap in the same cycle loads pending with no overflow.
    - pending empty and cap: load in_data straight to active and emit its element 0, cnt<=1. No gap.
    - otherwise: out_valid<=0, out_last<=0, out_data<=0, go to IDLE.
- Element order: index 0 first, then ascending. A vector occupies exactly NN consecutive out_valid cycles.
- cap in SEND with cnt<NN:
  - pending empty: store in pending, pending_valid<=1.
  - pending full: drop the new vector, overflow<=1; active and pending are unaffected.
- While out_valid=0, out_data=0 and out_last=0.
- busy = (state==SEND) || pending_valid, combinational from registers.
- clr_err clears overflow and valid_mismatch on the next edge. If set and clear happen in the same cycle, set wins.
- cnt width is clog2(NN+1). Data is passed bit-exact, with no arithmetic on it.

Test Plan:
- NN=4, dataWidth=16. Reset, then in_valid=4'hF for 1 cycle with elements {0x0011,0x0022,0x0033,0x0044} -> out_valid high 4 cycles starting 1 cycle later, out_data 0x0011,0x0022,0x0033,0x0044, out_last only on 0x0044, then busy=0.
- Back-to-back: vector A, then vector B captured 2 cycles later -> 8 contiguous out_valid cycles A0..A3,B0..B3, out_last on A3 and B3, overflow=0.
- Capture coinciding with the cycle A3 is on the outputs, pending empty -> B0 follows A3 with no gap.
- Three vectors captured on consecutive cycles -> A and B streamed, C dropped, overflow=1 sticky. Pulse clr_err -> overflow=0.
- in_valid=4'b0101 for 1 cycle -> no out_valid, valid_mismatch=1. clr_err together with another partial valid -> flag stays 1.
- Assert rst during element 2 of a vector with one pending -> all outputs 0 immediately. After release, no further out_valid until a new capture.
